pic_frame_streamer: RTL

PIC_FRAME_STREAMER -- requirements
Module: pic_frame_streamer

---
 rtl/pic_frame_streamer_pkg.sv | 16 +
 rtl/pic_rom.sv | 36 +++
 rtl/pic_frame_streamer.sv | 100 ++++++++++
 3 files changed

// File: rtl/pic_frame_streamer_pkg.sv
// pic_frame_streamer_pkg: shared widths, defaults, FSM encoding and brightness scaling.
package pic_frame_streamer_pkg;
  localparam int PIX_W = 24;
  localparam int LED_NUM_DEF = 64;
  localparam int PIC_NUM_DEF = 4;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WAIT, S_SEND} state_t;

  function automatic logic [7:0] scale_ch(input logic [7:0] ch, input logic [7:0] b);
    return 8'(({8'd0, ch} * ({8'd0, b} + 16'd1)) >> 8);
  endfunction

  function automatic logic [PIX_W-1:0] scale_pix(input logic [PIX_W-1:0] px, input logic [7:0] b);
    return {scale_ch(px[23:16], b), scale_ch(px[15:8], b), scale_ch(px[7:0], b)};
  endfunction
endpackage

// File: rtl/pic_rom.sv
// pic_rom: 8x8 gesture icons (U green, D red, L blue, R white), {pic,index} address, 1-cycle read.
module pic_rom
  import pic_frame_streamer_pkg::*;
#(
  parameter int LED_NUM = LED_NUM_DEF,
  parameter int PIC_NUM = PIC_NUM_DEF,
  localparam int IW = $clog2(LED_NUM),
  localparam int PW = PIC_NUM > 1 ? $clog2(PIC_NUM) : 1
) (
  input  logic               clk_i,
  input  logic [PW+IW-1:0]   addr_i,
  output logic [PIX_W-1:0]   data_o
);
  function automatic logic [PIX_W-1:0] pix_fn(input int p, input int i);
    int r, c;
    r = i / 8;
    c = i % 8;
    return p == 0 ? ((((c == 1 || c == 6) && r >= 1 && r <= 6) || (r == 6 && c >= 1 && c <= 6)) ? 24'hFF0000 : 24'h0)
         : p == 1 ? (((c == 1 && r >= 1 && r <= 6) || ((r == 1 || r == 6) && c >= 1 && c <= 5) ||
                      (c == 6 && r >= 2 && r <= 5)) ? 24'h00FF00 : 24'h0)
         : p == 2 ? (((c == 1 && r >= 1 && r <= 6) || (r == 6 && c >= 1 && c <= 6)) ? 24'h0000FF : 24'h0)
         : p == 3 ? (((r == 0 && c <= 5) || r == 1 || c == 1 || (c == 6 && r >= 2 && r <= 3) || r == 4 ||
                      (r >= 5 && c == r)) ? 24'hFFFFFF : 24'h0)
         : 24'h0;
  endfunction

  int pic, idx;

  always_comb begin
    pic = int'(addr_i[PW+IW-1:IW]);
    idx = int'(addr_i[IW-1:0]);
  end

  always_ff @(posedge clk_i)
    data_o <= (pic >= PIC_NUM || idx >= LED_NUM) ? '0 : pix_fn(pic, idx);
endmodule

// File: rtl/pic_frame_streamer.sv
// pic_frame_streamer: streams one brightness-scaled picture per frame_req over a valid/ready pixel port,
// optionally auto-cycling pictures every CYCLE_FRAMES frames.
module pic_frame_streamer
  import pic_frame_streamer_pkg::*;
#(
  parameter int LED_NUM = LED_NUM_DEF,
  parameter int PIC_NUM = PIC_NUM_DEF,
  parameter int CYCLE_FRAMES = 60,
  localparam int IW = $clog2(LED_NUM),
  localparam int PW = PIC_NUM > 1 ? $clog2(PIC_NUM) : 1,
  localparam int CW = $clog2(CYCLE_FRAMES + 1)
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [PW-1:0]    pic_sel,
  input  logic             pic_sel_vld,
  input  logic             mode,
  input  logic [7:0]       bright,
  input  logic             frame_req,
  output logic [PIX_W-1:0] pix_data,
  output logic             pix_vld,
  input  logic             pix_rdy,
  output logic             pix_last,
  output logic             busy,
  output logic             frame_done,
  output logic [PW-1:0]    cur_pic
);
  localparam logic [PW-1:0] PIC_MAX = PW'(PIC_NUM - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(LED_NUM - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CYCLE_FRAMES - 1);

  state_t           state_q;
  logic [IW-1:0]    idx_q;
  logic [PW-1:0]    pic_f_q, cur_pic_q, cur_pic_d;
  logic [7:0]       bright_f_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PIX_W-1:0] pix_data_q, rom_data;
  logic             pix_vld_q, pix_last_q, hs, adv;

  pic_rom #(.LED_NUM(LED_NUM), .PIC_NUM(PIC_NUM)) u_rom (
    .clk_i (sys_clk),
    .addr_i({pic_f_q, idx_q}),
    .data_o(rom_data)
  );

  assign hs = state_q == S_SEND && pix_rdy;
  assign frame_done = hs && pix_last_q;
  assign adv = mode && frame_done && cnt_q == CNT_LAST;

  // An explicit selection overrides a coinciding auto advance; the advance still clears the counter.
  always_comb begin
    cur_pic_d = pic_sel_vld ? (pic_sel > PIC_MAX ? '0 : pic_sel)
              : adv ? (cur_pic_q == PIC_MAX ? '0 : cur_pic_q + 1'b1) : cur_pic_q;
    cnt_d = !mode ? '0 : !frame_done ? cnt_q : cnt_q == CNT_LAST ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      pic_f_q    <= '0;
      bright_f_q <= '0;
      cur_pic_q  <= '0;
      cnt_q      <= '0;
      pix_data_q <= '0;
      pix_vld_q  <= 1'b0;
      pix_last_q <= 1'b0;
    end else begin
      cur_pic_q <= cur_pic_d;
      cnt_q     <= cnt_d;
      case (state_q)
        S_IDLE: if (frame_req) begin
          state_q    <= S_READ;
          idx_q      <= '0;
          pic_f_q    <= cur_pic_q;
          bright_f_q <= bright;
        end
        S_READ: state_q <= S_WAIT;
        S_WAIT: begin
          state_q    <= S_SEND;
          pix_vld_q  <= 1'b1;
          pix_data_q <= scale_pix(rom_data, bright_f_q);
          pix_last_q <= idx_q == IDX_LAST;
        end
        S_SEND: if (pix_rdy) begin
          state_q    <= pix_last_q ? S_IDLE : S_READ;
          idx_q      <= pix_last_q ? '0 : idx_q + 1'b1;
          pix_vld_q  <= 1'b0;
          pix_last_q <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end

  assign pix_data = pix_data_q;
  assign pix_vld  = pix_vld_q;
  assign pix_last = pix_last_q;
  assign busy     = state_q != S_IDLE;
  assign cur_pic  = cur_pic_q;
endmodule
